// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared divider state encoding, constants and helpers
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIX   = 3'd3,
        ST_WRITE = 3'd4
    } div_state_t;

    localparam int          DIV_ITERS      = 32;
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    // two's-complement negate when en is set, pass-through otherwise
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract divide iteration
module div_step
    import mips_pkg::*;
(
    input  logic [31:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        dvd_bit,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // shift in next dividend bit; keep the difference only if it did not go negative
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/hilo_div_seq.sv
// rtl/hilo_div_seq.sv - multi-cycle HI/LO divider (DIV/DIVU); signed ops enabled by HILO_DIV_SIGNED_EN
module hilo_div_seq
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    input  logic        mf_req,
    output logic        op_ready,
    output logic        busy,
    output logic        stall,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

`ifdef HILO_DIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    div_state_t  state;
    div_state_t  next_state;

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        sgn_reg;
    logic        sgn_eff;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] rem_next;
    logic        q_bit;

    assign sgn_eff = sgn_reg & SIGNED_EN;

    div_step u_step (
        .rem_in  (rem),
        .divisor (dvs),
        .dvd_bit (quo[31]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // next-state and status outputs; cancel always wins back to IDLE
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        hilo_we    = 1'b0;
        case (state)
            ST_IDLE:  if (op_valid) next_state = ST_PREP;
            ST_PREP:  next_state = (b_reg == 32'd0) ? ST_WRITE : ST_ITER;
            ST_ITER:  if (cnt == 6'(DIV_ITERS - 1)) next_state = ST_FIX;
            ST_FIX:   next_state = ST_WRITE;
            ST_WRITE: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (cancel) next_state = ST_IDLE;
        busy     = (state != ST_IDLE);
        hilo_we  = (state == ST_WRITE);
        op_ready = ~busy;
        stall    = mf_req & busy;
    end

    // operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sgn_reg    <= 1'b0;
            quo        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            hilo_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid && !cancel) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sgn_reg <= op_signed;
                    end
                end
                ST_PREP: begin
                    quo   <= neg_if(a_reg, sgn_eff & a_reg[31]);
                    dvs   <= neg_if(b_reg, sgn_eff & b_reg[31]);
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= sgn_eff & (a_reg[31] ^ b_reg[31]);
                    r_neg <= sgn_eff & a_reg[31];
                end
                ST_ITER: begin
                    quo <= {quo[30:0], q_bit};
                    rem <= rem_next;
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
            // result only changes on entry to WRITE, so it holds otherwise
            if (next_state == ST_WRITE && state != ST_WRITE) begin
                if (state == ST_PREP) hilo_wdata <= {a_reg, DIV_BY_ZERO_LO};
                else                  hilo_wdata <= {neg_if(rem, r_neg), neg_if(quo, q_neg)};
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_seq.sv
// tb/tb_hilo_div_seq.sv - self-checking bench for hilo_div_seq
module tb_hilo_div_seq;

`ifdef HILO_DIV_SIGNED_EN
    localparam bit SIGNED_ON = 1'b1;
`else
    localparam bit SIGNED_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        cancel = 1'b0;
    logic        mf_req = 1'b0;
    logic        op_ready;
    logic        busy;
    logic        stall;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    int          m_phase = 0;
    int          m_lat = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_wdata = '0;

    hilo_div_seq dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_signed  (op_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .cancel     (cancel),
        .mf_req     (mf_req),
        .op_ready   (op_ready),
        .busy       (busy),
        .stall      (stall),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s && SIGNED_ON) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // transaction-level model: accept, count cycles to the write, cancel/reset abort
    always @(posedge clk) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_phase = 0;
            m_wdata = '0;
        end else if (cancel) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (op_valid) begin
                m_busy  = 1'b1;
                m_phase = 1;
                m_res   = ref_div(op_a, op_b, op_signed);
                m_lat   = (op_b == 32'd0) ? 2 : 35;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == m_lat)     m_wdata = m_res;
            else if (m_phase > m_lat) m_busy = 1'b0;
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // every-cycle compare of all outputs against the model
    always begin
        @(negedge clk);
        #1;
        if (chk_en)
            check("cycle", {4'b0, op_ready, busy, stall, hilo_we, hilo_wdata},
                  {4'b0, ~m_busy, m_busy, mf_req & m_busy, m_busy && (m_phase == m_lat), m_wdata});
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp_w, input int exp_cyc);
        int          we_cnt;
        int          we_cyc;
        logic [63:0] we_data;
        op_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_signed = s;
        @(posedge clk);
        we_cnt  = 0;
        we_cyc  = -1;
        we_data = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
            #1;
            if (hilo_we) begin
                we_cnt++;
                we_cyc  = c;
                we_data = hilo_wdata;
            end
        end
        check({name, " data"},  {8'b0, we_data}, {8'b0, exp_w});
        check({name, " cycle"}, 72'(we_cyc), 72'(exp_cyc));
        check({name, " count"}, 72'(we_cnt), 72'd1);
    endtask

    initial begin
        int we_cnt;
        mf_req = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("reset outputs", {4'b0, op_ready, busy, stall, hilo_we, hilo_wdata}, {4'b0, 4'b1000, 64'd0});
        @(negedge clk);
        reset  = 1'b1;
        mf_req = 1'b0;
        @(negedge clk);

        run_op("divu 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 35);
`ifdef HILO_DIV_SIGNED_EN
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 35);
        run_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 35);
`else
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'h1, 32'h7FFF_FFFC}, 35);
        run_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0}, 35);
`endif
        run_op("divu 5/0", 32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 2);
        run_op("div -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2);
        run_op("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 35);
        run_op("divu 7/100", 32'd7, 32'd100, 1'b0, {32'd7, 32'd0}, 35);
        run_op("divu mid", 32'hDEAD_BEEF, 32'h0001_2345, 1'b0, ref_div(32'hDEAD_BEEF, 32'h0001_2345, 1'b0), 35);

        // cancel mid-divide with a stray request during ITER and mf_req held
        mf_req   = 1'b1;
        op_valid = 1'b1;
        op_a     = 32'd100;
        op_b     = 32'd7;
        op_signed = 1'b0;
        @(posedge clk);
        we_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            op_valid = (c == 5);
            op_a     = (c == 5) ? 32'd1000 : 32'd100;
            cancel   = (c == 10);
            #1;
            if (hilo_we) we_cnt++;
            if (c == 9)  check("stall while busy", {70'b0, busy, stall}, {70'b0, 2'b11});
            if (c == 11) check("cancel idle", {70'b0, busy, stall}, 72'd0);
        end
        check("cancel no write", 72'(we_cnt), 72'd0);
        mf_req = 1'b0;

        // cancel beats a simultaneous request in IDLE
        op_valid = 1'b1;
        cancel   = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        cancel   = 1'b0;
        #1;
        check("cancel vs op_valid", {71'b0, busy}, 72'd0);
        @(negedge clk);

        // reset in cycle 20 of a divide, then a clean divide
        mf_req   = 1'b1;
        op_valid = 1'b1;
        op_a     = 32'd100;
        op_b     = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("mid reset", {4'b0, op_ready, busy, stall, hilo_we, hilo_wdata}, {4'b0, 4'b1000, 64'd0});
        reset  = 1'b1;
        mf_req = 1'b0;
        @(negedge clk);
        run_op("after reset", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
